// File: rtl/dcache_ctrl_if.sv
// Signal bundle between dcache_ctrl and its environment: the CPU word
// load/store port and the Dmem 256-bit block port.
interface dcache_ctrl_if #(
    parameter int MEM_ADDR_W = 5
);
    logic                    cpu_ren;
    logic                    cpu_wen;
    logic [MEM_ADDR_W+4:0]   cpu_addr;
    logic [31:0]             cpu_wdata;
    logic [31:0]             cpu_rdata;
    logic                    cpu_stall;
    logic                    mem_ren;
    logic                    mem_wen;
    logic [MEM_ADDR_W-1:0]   mem_block_address;
    logic [255:0]            mem_din;
    logic [255:0]            mem_dout;
    logic                    mem_ready;
    logic                    mem_done;

    // The cache controller is the slave of the CPU and the master of Dmem.
    modport slave (
        input  cpu_ren, cpu_wen, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        output mem_ren, mem_wen, mem_block_address, mem_din,
        input  mem_dout, mem_ready, mem_done
    );

    modport master (
        output cpu_ren, cpu_wen, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        input  mem_ren, mem_wen, mem_block_address, mem_din,
        output mem_dout, mem_ready, mem_done
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller with
// zero-cycle hits and whole-block writeback/refill through Dmem.
module dcache_ctrl #(
    parameter int NUM_LINES  = 4,
    parameter int MEM_ADDR_W = 5
) (
    input logic          clock,
    input logic          reset,
    dcache_ctrl_if.slave bus
);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = MEM_ADDR_W - IDX_W;
    localparam int ADDR_W = MEM_ADDR_W + 5;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t                state_q, state_d;
    logic [NUM_LINES-1:0]  lineValid_q, lineDirty_q;
    logic [TAG_W-1:0]      lineTag_q  [NUM_LINES];
    logic [255:0]          lineData_q [NUM_LINES];
    logic [MEM_ADDR_W-1:0] reqBlk_q, reqBlk_d;
    logic                  memRen_q, memRen_d;
    logic                  memWen_q, memWen_d;
    logic [MEM_ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [255:0]          memDin_q, memDin_d;

    logic [IDX_W-1:0]      cpuIdx, reqIdx;
    logic [TAG_W-1:0]      cpuTag, reqTag;
    logic [2:0]            cpuWord;
    logic                  cpuReq, cpuHit, storeHit, wbDone, refillDone;
    logic                  unusedByteBits;

    assign cpuWord        = bus.cpu_addr[4:2];
    assign cpuIdx         = bus.cpu_addr[IDX_W+4:5];
    assign cpuTag         = bus.cpu_addr[ADDR_W-1:IDX_W+5];
    assign unusedByteBits = ^bus.cpu_addr[1:0];
    assign reqIdx         = reqBlk_q[IDX_W-1:0];
    assign reqTag         = reqBlk_q[MEM_ADDR_W-1:IDX_W];

    assign cpuReq     = bus.cpu_ren | bus.cpu_wen;
    assign cpuHit     = lineValid_q[cpuIdx] && (lineTag_q[cpuIdx] == cpuTag);
    assign storeHit   = (state_q == IDLE) && bus.cpu_wen && cpuHit;
    assign wbDone     = (state_q == WRITEBACK) && memWen_q && bus.mem_done;
    assign refillDone = (state_q == ALLOCATE) && memRen_q && bus.mem_done;

    // Reset also resets the CPU, so nothing is stalled or returned while it is high.
    assign bus.cpu_stall = ~reset & ((state_q != IDLE) | (cpuReq & ~cpuHit));
    assign bus.cpu_rdata = (~reset && state_q == IDLE && bus.cpu_ren && !bus.cpu_wen && cpuHit)
                         ? lineData_q[cpuIdx][{cpuWord, 5'b0} +: 32] : 32'h0;

    assign bus.mem_ren           = memRen_q;
    assign bus.mem_wen           = memWen_q;
    assign bus.mem_block_address = memAddr_q;
    assign bus.mem_din           = memDin_q;

    // Address and data are only loaded together with raising a request, so
    // they stay frozen for the whole Dmem handshake.
    always_comb begin
        state_d   = state_q;
        reqBlk_d  = reqBlk_q;
        memRen_d  = memRen_q;
        memWen_d  = memWen_q;
        memAddr_d = memAddr_q;
        memDin_d  = memDin_q;
        unique case (state_q)
            IDLE: begin
                if (cpuReq && !cpuHit) begin
                    reqBlk_d = {cpuTag, cpuIdx};
                    state_d  = (lineValid_q[cpuIdx] && lineDirty_q[cpuIdx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (!memWen_q) begin
                    if (bus.mem_ready) begin
                        memWen_d  = 1'b1;
                        memAddr_d = {lineTag_q[reqIdx], reqIdx};
                        memDin_d  = lineData_q[reqIdx];
                    end
                end else if (bus.mem_done) begin
                    memWen_d = 1'b0;
                    state_d  = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (!memRen_q) begin
                    if (bus.mem_ready) begin
                        memRen_d  = 1'b1;
                        memAddr_d = reqBlk_q;
                    end
                end else if (bus.mem_done) begin
                    memRen_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            reqBlk_q    <= '0;
            memRen_q    <= 1'b0;
            memWen_q    <= 1'b0;
            memAddr_q   <= '0;
            memDin_q    <= '0;
            lineValid_q <= '0;
            lineDirty_q <= '0;
        end else begin
            state_q   <= state_d;
            reqBlk_q  <= reqBlk_d;
            memRen_q  <= memRen_d;
            memWen_q  <= memWen_d;
            memAddr_q <= memAddr_d;
            memDin_q  <= memDin_d;
            if (wbDone) begin
                lineDirty_q[reqIdx] <= 1'b0;
            end
            if (refillDone) begin
                lineValid_q[reqIdx] <= 1'b1;
                lineDirty_q[reqIdx] <= 1'b0;
            end
            if (storeHit) begin
                lineDirty_q[cpuIdx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits alone guard them.
    always_ff @(posedge clock) begin
        if (refillDone) begin
            lineData_q[reqIdx] <= bus.mem_dout;
            lineTag_q[reqIdx]  <= reqTag;
        end
        if (storeHit) begin
            lineData_q[cpuIdx][{cpuWord, 5'b0} +: 32] <= bus.cpu_wdata;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a Dmem model, a word-level memory model
// that predicts CPU results and Dmem traffic, and independent monitors.
module tb_dcache_ctrl;
    localparam int NUM_LINES  = 4;
    localparam int MEM_ADDR_W = 5;
    localparam int ADDR_W     = MEM_ADDR_W + 5;
    localparam int NUM_BLOCKS = 1 << MEM_ADDR_W;

    typedef struct packed {
        logic        isLoad;
        logic [31:0] data;
    } cpuExp_t;

    typedef struct packed {
        logic                  isWrite;
        logic [MEM_ADDR_W-1:0] blk;
        logic [255:0]          din;
    } memExp_t;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    cpuExp_t cpuExpQ[$];
    memExp_t memExpQ[$];

    logic [255:0] dmem  [NUM_BLOCKS];
    logic [31:0]  truth [NUM_BLOCKS][8];
    bit           mValid[NUM_LINES];
    bit           mDirty[NUM_LINES];
    int           mBlk  [NUM_LINES];

    dcache_ctrl_if #(.MEM_ADDR_W(MEM_ADDR_W)) bus ();

    dcache_ctrl #(.NUM_LINES(NUM_LINES), .MEM_ADDR_W(MEM_ADDR_W)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic finishRun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic logic [255:0] truthBlock(input int b);
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[w*32 +: 32] = truth[b][w];
        return v;
    endfunction

    // Cache contents tracked only as "which block sits in each line, and is it dirty";
    // the true value of every word lives in truth[].
    task automatic modelReset();
        for (int i = 0; i < NUM_LINES; i++) begin
            mValid[i] = 0;
            mDirty[i] = 0;
            mBlk[i]   = 0;
        end
        for (int b = 0; b < NUM_BLOCKS; b++)
            for (int w = 0; w < 8; w++) truth[b][w] = dmem[b][w*32 +: 32];
        cpuExpQ.delete();
        memExpQ.delete();
    endtask

    task automatic predict(input bit isStore, input logic [ADDR_W-1:0] addr,
                           input logic [31:0] wd, output bit miss);
        int      blk, idx, w;
        memExp_t m;
        cpuExp_t c;
        blk  = int'(addr[ADDR_W-1:5]);
        idx  = blk % NUM_LINES;
        w    = int'(addr[4:2]);
        miss = !(mValid[idx] && mBlk[idx] == blk);
        if (miss) begin
            if (mValid[idx] && mDirty[idx]) begin
                m.isWrite = 1'b1;
                m.blk     = MEM_ADDR_W'(mBlk[idx]);
                m.din     = truthBlock(mBlk[idx]);
                memExpQ.push_back(m);
            end
            m.isWrite = 1'b0;
            m.blk     = MEM_ADDR_W'(blk);
            m.din     = '0;
            memExpQ.push_back(m);
            mValid[idx] = 1;
            mDirty[idx] = 0;
            mBlk[idx]   = blk;
        end
        if (isStore) begin
            truth[blk][w] = wd;
            mDirty[idx]   = 1;
            c.isLoad      = 1'b0;
            c.data        = '0;
        end else begin
            c.isLoad = 1'b1;
            c.data   = truth[blk][w];
        end
        cpuExpQ.push_back(c);
    endtask

    // kind: 0 = load, 1 = store, 2 = ren and wen together (behaves as a store)
    task automatic applyStimulus(input int kind, input logic [ADDR_W-1:0] addr, input logic [31:0] wd);
        bit miss;
        bit done;
        predict(kind != 0, addr, wd, miss);
        @(posedge clock);
        #1;
        bus.cpu_ren   = (kind != 1);
        bus.cpu_wen   = (kind != 0);
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        #1 checkOutput("stall_on_issue", bus.cpu_stall, miss);
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clock);
            done = !bus.cpu_stall;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL request_timeout: addr %0h still stalled, expected completion", addr);
            finishRun();
        end
        @(posedge clock);
        #1;
        bus.cpu_ren = 1'b0;
        bus.cpu_wen = 1'b0;
    endtask

    // CPU-side monitor: pops one expectation per completed request.
    initial begin
        cpuExp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (bus.cpu_ren || bus.cpu_wen) begin
                    if (!bus.cpu_stall) begin
                        if (cpuExpQ.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_completion: addr %0h, expected none", bus.cpu_addr);
                        end else begin
                            e = cpuExpQ.pop_front();
                            if (e.isLoad) checkOutput("load_data", bus.cpu_rdata, e.data);
                        end
                    end
                end else begin
                    checkOutput("idle_stall", bus.cpu_stall, 0);
                    checkOutput("idle_rdata", bus.cpu_rdata, 0);
                end
            end
        end
    end

    // Dmem model with random latency and ready gaps; also checks the Dmem handshake.
    initial begin
        bit           busy;
        int           cnt;
        int           gap;
        logic         isW;
        logic [MEM_ADDR_W-1:0] a;
        logic [255:0] d;
        memExp_t      m;
        busy = 0;
        gap  = 0;
        cnt  = 0;
        isW  = 0;
        a    = '0;
        d    = '0;
        bus.mem_ready = 1'b1;
        bus.mem_done  = 1'b0;
        bus.mem_dout  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                busy = 0;
                gap  = 0;
                bus.mem_ready = 1'b1;
                bus.mem_done  = 1'b0;
            end else begin
                checkOutput("ren_wen_exclusive", bus.mem_ren & bus.mem_wen, 0);
                if (bus.mem_done) begin
                    checkOutput("req_dropped", {bus.mem_wen, bus.mem_ren}, 0);
                    bus.mem_done  = 1'b0;
                    busy          = 0;
                    gap           = $urandom_range(0, 1);
                    bus.mem_ready = (gap == 0);
                end else if (busy) begin
                    checkOutput("req_held", {bus.mem_wen, bus.mem_ren}, {isW, !isW});
                    checkOutput("addr_held", bus.mem_block_address, a);
                    if (isW) checkOutput("din_held", bus.mem_din, d);
                    cnt--;
                    if (cnt == 0) begin
                        if (isW) dmem[a] = d;
                        else bus.mem_dout = dmem[a];
                        bus.mem_done = 1'b1;
                    end
                end else if (gap > 0) begin
                    gap--;
                    if (gap == 0) bus.mem_ready = 1'b1;
                end else if (bus.mem_ren || bus.mem_wen) begin
                    isW  = bus.mem_wen;
                    a    = bus.mem_block_address;
                    d    = bus.mem_din;
                    busy = 1;
                    cnt  = $urandom_range(1, 4);
                    bus.mem_ready = 1'b0;
                    if (memExpQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_mem_op: wen %0d addr %0h, expected none", isW, a);
                    end else begin
                        m = memExpQ.pop_front();
                        checkOutput("mem_op_is_write", isW, m.isWrite);
                        checkOutput("mem_block_address", a, m.blk);
                        if (m.isWrite) checkOutput("writeback_data", d, m.din);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        finishRun();
    end

    initial begin
        bit                miss;
        bit                gotRen;
        int                kind;
        logic [MEM_ADDR_W-1:0] blkSel;
        logic [ADDR_W-1:0] addr;
        reset         = 1'b1;
        bus.cpu_ren   = 1'b0;
        bus.cpu_wen   = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        for (int b = 0; b < NUM_BLOCKS; b++)
            for (int w = 0; w < 8; w++) dmem[b][w*32 +: 32] = 32'(b * 16 + w + 1);
        modelReset();
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_mem_ren", bus.mem_ren, 0);
        checkOutput("reset_mem_wen", bus.mem_wen, 0);
        checkOutput("reset_mem_addr", bus.mem_block_address, 0);
        checkOutput("reset_mem_din", bus.mem_din, 0);
        checkOutput("reset_stall", bus.cpu_stall, 0);
        checkOutput("reset_rdata", bus.cpu_rdata, 0);
        reset = 1'b0;

        $display("[TB] directed sequence");
        applyStimulus(0, 10'h000, 32'h0);
        applyStimulus(1, 10'h004, 32'hDEADBEEF);
        applyStimulus(0, 10'h004, 32'h0);
        applyStimulus(0, 10'h080, 32'h0);
        applyStimulus(0, 10'h004, 32'h0);
        applyStimulus(2, 10'h024, 32'h12345678);
        applyStimulus(0, 10'h024, 32'h0);

        $display("[TB] reset during refill");
        predict(1'b0, 10'h044, 32'h0, miss);
        @(posedge clock);
        #1;
        bus.cpu_ren  = 1'b1;
        bus.cpu_addr = 10'h044;
        gotRen = 0;
        for (int c = 0; c < 100 && !gotRen; c++) begin
            @(negedge clock);
            gotRen = bus.mem_ren;
        end
        checkOutput("refill_started", gotRen, 1);
        #1;
        reset       = 1'b1;
        bus.cpu_ren = 1'b0;
        #1;
        checkOutput("reset_drops_mem_ren", bus.mem_ren, 0);
        checkOutput("reset_drops_mem_wen", bus.mem_wen, 0);
        checkOutput("reset_drops_stall", bus.cpu_stall, 0);
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_clears_addr", bus.mem_block_address, 0);
        checkOutput("reset_clears_din", bus.mem_din, 0);
        reset = 1'b0;
        modelReset();
        applyStimulus(0, 10'h044, 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            kind   = $urandom_range(0, 2);
            blkSel = ($urandom_range(0, 3) == 0) ? MEM_ADDR_W'($urandom_range(0, NUM_BLOCKS - 1))
                                                 : MEM_ADDR_W'($urandom_range(0, 7));
            addr   = {blkSel, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            applyStimulus(kind, addr, $urandom());
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end

        repeat (4) @(posedge clock);
        checkOutput("cpu_queue_drained", cpuExpQ.size(), 0);
        checkOutput("mem_queue_drained", memExpQ.size(), 0);
        finishRun();
    end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate L1 data cache controller. Sits between the CPU memory stage and the 32-block Dmem backing store. Serves 32-bit word loads and stores from the CPU, and issues whole 256-bit block reads and writebacks to Dmem through its ren/wen/ready/done handshake.

Parameters:
NUM_LINES, 4, number of cache lines; power of two, 2..32; IDX_W = log2(NUM_LINES)
MEM_ADDR_W, 5, Dmem block address width; CPU byte address width = MEM_ADDR_W+5

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cpu_ren  in  1  load request
cpu_wen  in  1  store request; wins if asserted together with cpu_ren
cpu_addr  in  MEM_ADDR_W+5  byte address; [1:0] ignored, [4:2] word offset, [IDX_W+4:5] index, upper bits tag
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, valid when cpu_ren=1 and cpu_stall=0
cpu_stall  out  1  CPU must hold all request inputs while high
mem_ren  out  1  Dmem block read request
mem_wen  out  1  Dmem block write request
mem_block_address  out  MEM_ADDR_W  Dmem block address
mem_din  out  256  writeback block
mem_dout  in  256  block returned by Dmem
mem_ready  in  1  Dmem idle and able to accept a request
mem_done  in  1  one-cycle pulse: Dmem operation complete

Behaviour:
- Storage per line: valid, dirty, tag, and 256-bit data. Reset clears valid and dirty only. Data and tag arrays are not reset.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- Reset, asynchronous: state=IDLE, mem_ren=0, mem_wen=0, mem_block_address=0, mem_din=0, all valid/dirty=0, latched request cleared. cpu_stall=0 and cpu_rdata=0 while no request is present.
- Hit = valid[idx] && tag[idx]==addr tag. Evaluated combinationally in IDLE.
- IDLE, load hit: cpu_rdata = selected word combinationally, cpu_stall=0. Zero-cycle hit.
- IDLE, store hit: word written on the clock edge, dirty[idx]=1, cpu_stall=0.
- IDLE, miss (either op): cpu_stall=1 in the same cycle. Next state is WRITEBACK if valid&&dirty of the victim, otherwise ALLOCATE.
- WRITEBACK: when mem_ready=1, assert mem_wen with mem_block_address={victim tag, idx} and mem_din=victim line. Hold all three until mem_done. On mem_done: deassert mem_wen the next cycle, clear dirty[idx], go to ALLOCATE.
- ALLOCATE: when mem_ready=1, assert mem_ren with address {req tag, idx}. Hold until mem_done. On mem_done: write mem_dout into the line, set valid=1, dirty=0, tag=req tag, deassert mem_ren, go to IDLE.
- Back in IDLE the request now hits. A load returns data, or a store merges its word and sets dirty; stall drops in that cycle.
- Miss cost = writeback time (if dirty) + refill time + 1 cycle.
- cpu_stall=1 in every cycle the state is not IDLE.
- Never assert mem_ren and mem_wen together. Never change mem_block_address or mem_din while a request is asserted.
- mem_done outside WRITEBACK/ALLOCATE is ignored.
- Request inputs changing while stalled is a CPU protocol violation. The controller services the address latched at the miss.
- No request (ren=wen=0): no state change, cpu_stall=0.
- Reset mid-WRITEBACK/ALLOCATE: request lines drop immediately and the line is left invalid. Dmem is reset by the same signal.

Test Plan:
- Reset, then load 0x000 (Dmem block 0 word0 = 0x00000001) -> cpu_stall=1, mem_ren=1 with address 0, no mem_wen. After mem_done plus 1 cycle: cpu_rdata=0x00000001, stall=0.
- Store 0x004 data 0xDEADBEEF, then load 0x004 -> both complete with stall=0 and no mem_ren/mem_wen. Load returns 0xDEADBEEF.
- Load 0x080 (block 4, same index 0) -> mem_wen with address 0 and mem_din[63:32]=0xDEADBEEF first, then mem_ren with address 4. Then returns Dmem block 4 word0.
- Load 0x004 again -> no writeback because line 0 is clean. Refill of block 0 returns 0xDEADBEEF.
- cpu_ren=cpu_wen=1 at 0x024 with 0x12345678 -> treated as store. A following load of 0x024 returns 0x12345678.
- Assert reset during ALLOCATE (mem_ren high) -> mem_ren=0 and cpu_stall=0 before the next clock edge. A reload of the same address misses and refills again.
